// File: rtl/fifo_stream_reader.sv
// Prefetching FIFO-to-stream reader with a 2-entry skid buffer for one-cycle FIFO read latency.
// Optional accepted-word counter port word_cnt enabled by macro FIFO_READER_CNT_EN.
module fifo_stream_reader #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_rdata,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [CW-1:0] word_cnt
`endif
);

  logic [DW-1:0] buf0_r, buf1_r;
  logic [DW-1:0] buf0_nxt_s, buf1_nxt_s;
  logic [1:0]    buf_cnt_r, buf_cnt_nxt_s;
  logic          in_flight_r;
  logic          pop_s;
  logic [1:0]    occ_s;
  logic          rd_en_s;

  assign pop_s      = m_valid & m_ready;
  assign occ_s      = buf_cnt_r + {1'b0, in_flight_r};
  assign m_valid    = (buf_cnt_r != 2'd0);
  assign m_data     = buf0_r;
  assign fifo_rd_en = rd_en_s;

  // Pop request: keep buffered plus in-flight words at most two, counting a same-cycle pop as a free slot.
  always_comb begin
    rd_en_s = 1'b0;
    if (!RST && !fifo_empty) begin
      if (occ_s < 2'd2) begin
        rd_en_s = 1'b1;
      end else if ((occ_s == 2'd2) && pop_s) begin
        rd_en_s = 1'b1;
      end else begin
        rd_en_s = 1'b0;
      end
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Buffer next state: buf0 is always the oldest word, arriving data fills the first free slot.
  always_comb begin
    buf0_nxt_s    = buf0_r;
    buf1_nxt_s    = buf1_r;
    buf_cnt_nxt_s = buf_cnt_r;
    case ({in_flight_r, pop_s})
      2'b01: begin
        buf0_nxt_s    = buf1_r;
        buf_cnt_nxt_s = buf_cnt_r - 2'd1;
      end
      2'b10: begin
        if (buf_cnt_r == 2'd0) begin
          buf0_nxt_s = fifo_rdata;
        end else begin
          buf1_nxt_s = fifo_rdata;
        end
        buf_cnt_nxt_s = buf_cnt_r + 2'd1;
      end
      2'b11: begin
        // Capture and pop together: occupancy is unchanged, the queue just shifts.
        if (buf_cnt_r == 2'd1) begin
          buf0_nxt_s = fifo_rdata;
        end else begin
          buf0_nxt_s = buf1_r;
          buf1_nxt_s = fifo_rdata;
        end
      end
      default: begin
        buf_cnt_nxt_s = buf_cnt_r;
      end
    endcase
  end

  // State registers; reset drops buffered words and any word still in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      buf0_r      <= {DW{1'b0}};
      buf1_r      <= {DW{1'b0}};
      buf_cnt_r   <= 2'd0;
      in_flight_r <= 1'b0;
    end else begin
      buf0_r      <= buf0_nxt_s;
      buf1_r      <= buf1_nxt_s;
      buf_cnt_r   <= buf_cnt_nxt_s;
      in_flight_r <= rd_en_s;
    end
  end

`ifdef FIFO_READER_CNT_EN
  logic [CW-1:0] word_cnt_r;

  assign word_cnt = word_cnt_r;

  // Accepted-word counter, wraps naturally at 2^CW.
  always_ff @(posedge CLK) begin
    if (RST) begin
      word_cnt_r <= {CW{1'b0}};
    end else if (pop_s) begin
      word_cnt_r <= word_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      word_cnt_r <= word_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a FIFO model feeds the DUT, a monitor checks the output stream.
module tb_fifo_stream_reader;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rdata = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
`ifdef FIFO_READER_CNT_EN
  logic [CW-1:0] word_cnt;
`endif

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  bit            pend = 1'b0;
  logic [DW-1:0] pend_data = '0;
  logic          t_rd, t_vld;
  logic [DW-1:0] t_dat;
  logic [31:0]   vm, rm;

  always #5 CLK = ~CLK;

  fifo_stream_reader #(.DW(DW), .CW(CW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_READER_CNT_EN
    ,
    .word_cnt   (word_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: drive inputs at negedge, then sample DUT and pop the FIFO model if a read was issued.
  task automatic step(input bit rst, input bit rdy, input bit gate);
    @(negedge CLK);
    RST        = rst;
    m_ready    = rdy;
    fifo_rdata = pend ? pend_data : (32'hBAD0_0000 ^ 32'(cyc));
    pend       = 1'b0;
    fifo_empty = gate || (src_q.size() == 0);
    #1;
    t_rd  = fifo_rd_en;
    t_vld = m_valid;
    t_dat = m_data;
    if (fifo_empty) chk("rd_en_while_empty", fifo_rd_en, 1'b0);
    if (fifo_rd_en === 1'b1 && src_q.size() != 0) begin
      pend_data = src_q.pop_front();
      pend      = 1'b1;
    end
    cyc++;
  endtask

  // Monitor: compare every accepted word against the scoreboard, and check stability under backpressure.
  initial begin
    bit            stall;
    logic [DW-1:0] sdat;
    stall = 1'b0;
    sdat  = '0;
    forever begin
      @(negedge CLK);
      #2;
      if (stall) begin
        chk("stall_valid", m_valid, 1'b1);
        chk("stall_data", m_data, sdat);
      end
      if (RST !== 1'b0) begin
        stall = 1'b0;
      end else begin
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", m_data, cyc);
          end else begin
            chk("scoreboard_data", m_data, exp_q.pop_front());
          end
        end
        stall = (m_valid === 1'b1) && (m_ready === 1'b0);
        sdat  = m_data;
      end
    end
  end

  initial begin
    // Reset with a non-empty FIFO
    src_q.push_back(32'hDEAD_BEEF);
    step(1'b1, 1'b1, 1'b0);
    chk("rst_rd_en_0", t_rd, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("rst_rd_en_1", t_rd, 1'b0);
    chk("rst_m_valid", t_vld, 1'b0);
    chk("rst_m_data", t_dat, 32'h0);
    src_q.delete();
    step(1'b0, 1'b1, 1'b1);
    chk("post_rst_m_valid", t_vld, 1'b0);
    chk("post_rst_m_data", t_dat, 32'h0);
`ifdef FIFO_READER_CNT_EN
    chk("rst_word_cnt", word_cnt, 4'd0);
`endif

    // Single word: read in cycle 0, presented in cycle 2 only
    src_q.push_back(32'hA5A5_0001);
    exp_q.push_back(32'hA5A5_0001);
    vm = '0; rm = '0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0);
      rm[i] = t_rd;
      vm[i] = t_vld;
      if (t_vld) chk("single_data", t_dat, 32'hA5A5_0001);
    end
    chk("single_rd_en", rm, 32'h0000_0001);
    chk("single_valid", vm, 32'h0000_0004);
`ifdef FIFO_READER_CNT_EN
    chk("single_word_cnt", word_cnt, 4'd1);
`endif

    // Burst 1..8 at full rate
    for (int w = 1; w <= 8; w++) begin
      src_q.push_back(32'(w));
      exp_q.push_back(32'(w));
    end
    vm = '0; rm = '0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0);
      rm[i] = t_rd;
      vm[i] = t_vld;
    end
    chk("burst_rd_en", rm, 32'h0000_00FF);
    chk("burst_valid", vm, 32'h0000_03FC);
`ifdef FIFO_READER_CNT_EN
    chk("burst_word_cnt", word_cnt, 4'd9);
`endif

    // Backpressure: m_ready low for cycles 4..8, FIFO reads must stop and data must freeze
    for (int w = 32'h11; w <= 32'h1A; w++) begin
      src_q.push_back(32'(w));
      exp_q.push_back(32'(w));
    end
    vm = '0; rm = '0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, !(i >= 4 && i <= 8), 1'b0);
      rm[i] = t_rd;
      vm[i] = t_vld;
      if (i >= 4 && i <= 8) chk("bp_frozen_data", t_dat, 32'h13);
    end
    chk("bp_rd_en", rm, 32'h0000_7E0F);
    chk("bp_valid", vm, 32'h0001_FFFC);
`ifdef FIFO_READER_CNT_EN
    chk("bp_word_cnt", word_cnt, 4'd3);
`endif

    // Reset while one word is buffered and one is in flight: both are dropped
    for (int w = 32'h21; w <= 32'h25; w++) src_q.push_back(32'(w));
    for (int w = 32'h23; w <= 32'h25; w++) exp_q.push_back(32'(w));
    step(1'b0, 1'b0, 1'b0);
    chk("mid_rst_rd_c0", t_rd, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("mid_rst_rd_c1", t_rd, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("mid_rst_rd_forced_low", t_rd, 1'b0);
    vm = '0; rm = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0);
      rm[i] = t_rd;
      vm[i] = t_vld;
      if (i == 0) chk("after_rst_m_data", t_dat, 32'h0);
      if (i == 2) chk("after_rst_first_word", t_dat, 32'h23);
    end
    chk("after_rst_rd_en", rm, 32'h0000_0007);
    chk("after_rst_valid", vm, 32'h0000_001C);
`ifdef FIFO_READER_CNT_EN
    chk("after_rst_word_cnt", word_cnt, 4'd3);

    // Counter wrap: 17 pops on a 4-bit counter
    step(1'b1, 1'b0, 1'b1);
    for (int w = 0; w < 17; w++) begin
      src_q.push_back(32'h100 + 32'(w));
      exp_q.push_back(32'h100 + 32'(w));
    end
    for (int i = 0; i < 22; i++) step(1'b0, 1'b1, 1'b0);
    chk("wrap_word_cnt", word_cnt, 4'd1);
`endif

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
